karatsuba_result_stage: RTL and testbench
=========================================

KARATSUBA_RESULT_STAGE -- requirements
Module: karatsuba_result_stage

Interface
REQ-001 SHALL have parameter MULT_LAT, default 2: cycles from operand issue to a valid product_i from the 24x24 Karatsuba multiplier; legal range 1..8.
REQ-002 SHALL have parameter FRAC_BITS, default 24: number of fraction bits removed from the 48-bit product; legal range 0..24.
REQ-003 SHALL have parameter OUT_W, default 24: result width; legal range 1..48.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: number of result buffer entries; power of two, 2..16.
REQ-005 SHALL have port clkn_i, input, width 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rstn_i, input, width 1: asynchronous reset, active-low.
REQ-007 SHALL have port issue_i, input, width 1: the upstream presents operands to the multiplier this cycle.
REQ-008 SHALL have port issue_ready_o, output, width 1: an issue is accepted this cycle.
REQ-009 SHALL have port product_i, input, width 48: the unsigned multiplier product.
REQ-010 SHALL have port res_valid_o, output, width 1: res_data_o and res_sat_o are valid.
REQ-011 SHALL have port res_ready_i, input, width 1: the downstream consumer accepts the result.
REQ-012 SHALL have port res_data_o, output, width OUT_W: the rounded and saturated result.
REQ-013 SHALL have port res_sat_o, output, width 1: the current result was saturated.

Function
REQ-014 SHALL treat an issue as accepted when issue_i=1 and issue_ready_o=1; issue_i while issue_ready_o=0 SHALL be ignored and leave no trace.
REQ-015 SHALL track accepted issues in a MULT_LAT-stage valid shift register; product_i SHALL be captured exactly in the cycle the final stage is 1, and ignored otherwise.
REQ-016 SHALL keep a credit counter: reset value FIFO_DEPTH; decremented on an accepted issue; incremented on a pop (res_valid_o & res_ready_i); unchanged when both occur in the same cycle.
REQ-017 SHALL drive issue_ready_o = (credits != 0) from registered state only, with no combinational path from issue_i or res_ready_i.
REQ-018 SHALL round half-up: form r = product_i + 2^(FRAC_BITS-1) at 49 bits, then q = r >> FRAC_BITS; when FRAC_BITS=0, q = product_i.
REQ-019 SHALL saturate: when q > 2^OUT_W-1, the stored data SHALL be all ones and the stored sat flag SHALL be 1; otherwise the data SHALL be q[OUT_W-1:0] and the flag SHALL be 0.
REQ-020 SHALL push {data, sat} into the FIFO in the capture cycle; an entry SHALL be visible on res_* in the following cycle, giving issue-to-res_valid_o latency MULT_LAT+1 cycles when the FIFO is empty.
REQ-021 SHALL hold res_valid_o high while the FIFO is non-empty, with res_data_o and res_sat_o stable until popped; results SHALL be delivered in issue order.
REQ-022 SHALL allow a push and a pop in the same cycle at any occupancy, including full, with occupancy unchanged.
REQ-023 SHALL never overflow or underflow the FIFO; a push when full without a pop, or a pop when empty, is a design error and SHALL be flagged by an assertion.
REQ-024 SHALL return credits to FIFO_DEPTH and empty the FIFO once all issues are drained.

Reset
REQ-025 SHALL, while rstn_i=0, clear the valid shift register, FIFO pointers and occupancy, and set credits to FIFO_DEPTH.
REQ-026 SHALL reset res_valid_o=0, res_data_o=0, res_sat_o=0 and issue_ready_o=1.
REQ-027 SHALL discard the products of operations in flight at reset; no result SHALL emerge for them after reset deassertion.

Configuration
REQ-028 SHALL, with macro RESULT_STICKY_SAT_EN defined, add input sat_clr_i (width 1) and output sat_sticky_o (width 1).
REQ-029 SHALL, with RESULT_STICKY_SAT_EN defined, set sat_sticky_o on any saturated push and clear it on sat_clr_i=1 or on reset; set SHALL win over clear when both occur in the same cycle.
REQ-030 SHALL, without RESULT_STICKY_SAT_EN, omit both ports and the sticky logic, and be otherwise identical.

Verification (defaults: MULT_LAT=2, FRAC_BITS=24, OUT_W=24, FIFO_DEPTH=4)
REQ-031 SHALL cover: a single issue with product_i=0x000001_800000 at the capture cycle -> res_valid_o rises 3 cycles after issue, res_data_o=0x000002, res_sat_o=0.
REQ-032 SHALL cover: product_i=0xFFFFFF_FFFFFF -> res_data_o=0xFFFFFF, res_sat_o=1; product_i=0x000003_7FFFFF -> res_data_o=0x000003, res_sat_o=0.
REQ-033 SHALL cover: res_ready_i=0 with issue_i held at 1 -> exactly 4 issues accepted, issue_ready_o=0 afterwards, 4 results held in order with no loss.
REQ-034 SHALL cover: full FIFO with res_ready_i=1 and issue_i=1 in the same cycle -> one pop and one issue, credits remain 0, order preserved.
REQ-035 SHALL cover: rstn_i pulsed low with 2 issues in flight -> no res_valid_o afterwards, issue_ready_o=1, credits=4.
REQ-036 SHALL cover, with RESULT_STICKY_SAT_EN: one saturated result -> sat_sticky_o=1 until a sat_clr_i pulse; sat_clr_i in the same cycle as a saturated push -> sat_sticky_o remains 1.

Source files
------------

// File: rtl/karatsuba_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : karatsuba_result_stage
// Brief    : Result stage behind a 24x24 Karatsuba multiplier. It tracks
//            operations in flight, rounds each product half-up, saturates it
//            and queues it in a credit-protected result FIFO.
//            Optional macro RESULT_STICKY_SAT_EN adds a sticky saturation flag.
// Revision : 1.0 - initial release
// ============================================================================
module karatsuba_result_stage #(
    parameter int MULT_LAT   = 2,
    parameter int FRAC_BITS  = 24,
    parameter int OUT_W      = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clkn_i,
    input  logic             rstn_i,
    input  logic             issue_i,
    output logic             issue_ready_o,
    input  logic [47:0]      product_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [OUT_W-1:0] res_data_o,
    output logic             res_sat_o
`ifdef RESULT_STICKY_SAT_EN
    ,
    input  logic             sat_clr_i,
    output logic             sat_sticky_o
`endif
);

    localparam int C_PTR_W = $clog2(FIFO_DEPTH);
    localparam int C_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(FIFO_DEPTH);

    logic [MULT_LAT-1:0]  vld_q, vld_d;
    logic [C_CNT_W-1:0]   credits_q, credits_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic [C_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OUT_W:0]       mem_q [FIFO_DEPTH];
    logic [OUT_W:0]       mem_d [FIFO_DEPTH];

    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_not_empty;
    logic                 w_full;
    logic [48:0]          w_quot;
    logic                 w_sat;
    logic [OUT_W-1:0]     w_data;

    assign issue_ready_o = (credits_q != '0);
    assign w_accept      = issue_i & issue_ready_o;
    assign w_not_empty   = (cnt_q != '0);
    assign w_full        = (cnt_q == C_DEPTH);
    assign w_push        = vld_q[MULT_LAT-1];
    assign w_pop         = w_not_empty & res_ready_i;

    generate
        if (MULT_LAT == 1) begin : g_vld_single
            always_comb vld_d = w_accept;
        end else begin : g_vld_shift
            always_comb vld_d = {vld_q[MULT_LAT-2:0], w_accept};
        end
    endgenerate

    // 49-bit sum so the rounding carry out of a full-scale product is kept.
    generate
        if (FRAC_BITS == 0) begin : g_round_bypass
            assign w_quot = {1'b0, product_i};
        end else begin : g_round_half_up
            localparam logic [48:0] C_HALF = 49'd1 << (FRAC_BITS - 1);
            logic [48:0] w_rounded;
            assign w_rounded = {1'b0, product_i} + C_HALF;
            assign w_quot    = w_rounded >> FRAC_BITS;
        end
    endgenerate

    assign w_sat  = |w_quot[48:OUT_W];
    assign w_data = w_sat ? {OUT_W{1'b1}} : w_quot[OUT_W-1:0];

    always_comb begin
        credits_d = credits_q;
        if (w_accept && !w_pop) begin
            credits_d = credits_q - C_CNT_W'(1);
        end else if (!w_accept && w_pop) begin
            credits_d = credits_q + C_CNT_W'(1);
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = {w_data, w_sat};
            wr_ptr_d        = wr_ptr_q + C_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
        end
        if (w_push && !w_pop) begin
            cnt_d = cnt_q + C_CNT_W'(1);
        end else if (!w_push && w_pop) begin
            cnt_d = cnt_q - C_CNT_W'(1);
        end
    end

    always_ff @(posedge clkn_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld_q     <= '0;
            credits_q <= C_DEPTH;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            vld_q     <= vld_d;
            credits_q <= credits_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_q     <= mem_d;
        end
    end

    // Outputs are forced to zero while empty so stale entries never show.
    always_comb begin
        res_valid_o = w_not_empty;
        res_data_o  = '0;
        res_sat_o   = 1'b0;
        if (w_not_empty) begin
            {res_data_o, res_sat_o} = mem_q[rd_ptr_q];
        end
    end

`ifdef RESULT_STICKY_SAT_EN
    logic sat_sticky_q, sat_sticky_d;

    always_comb begin
        sat_sticky_d = sat_sticky_q;
        if (w_push && w_sat) begin
            sat_sticky_d = 1'b1;
        end else if (sat_clr_i) begin
            sat_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clkn_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sat_sticky_q <= 1'b0;
        end else begin
            sat_sticky_q <= sat_sticky_d;
        end
    end

    assign sat_sticky_o = sat_sticky_q;
`endif

`ifndef SYNTHESIS
    a_no_overflow : assert property (@(posedge clkn_i) disable iff (!rstn_i)
        !(w_push && !w_pop && w_full));
    a_no_underflow : assert property (@(posedge clkn_i) disable iff (!rstn_i)
        !(w_pop && !w_not_empty));
`endif

endmodule
`default_nettype wire

// File: tb/tb_karatsuba_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_karatsuba_result_stage
// Brief    : Scoreboard bench for karatsuba_result_stage with a queue-based
//            reference model (credits, in-flight ops, rounding, saturation).
// Revision : 1.0 - initial release
// ============================================================================
module tb_karatsuba_result_stage;

    localparam int MULT_LAT   = 2;
    localparam int FRAC_BITS  = 24;
    localparam int OUT_W      = 24;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [OUT_W-1:0] d;
        logic             s;
    } res_t;

    logic             clkn_i      = 1'b0;
    logic             rstn_i      = 1'b0;
    logic             issue_i     = 1'b0;
    logic             res_ready_i = 1'b0;
    logic [47:0]      product_i   = '0;
    logic             issue_ready_o;
    logic             res_valid_o;
    logic [OUT_W-1:0] res_data_o;
    logic             res_sat_o;
`ifdef RESULT_STICKY_SAT_EN
    logic             sat_clr_i = 1'b0;
    logic             sat_sticky_o;
    bit               m_sticky;
`endif

    res_t exp_q[$];
    int   inflight[$];
    int   fifo_n;
    int   cyc;
    int   checks;
    int   errors;

    karatsuba_result_stage #(
        .MULT_LAT  (MULT_LAT),
        .FRAC_BITS (FRAC_BITS),
        .OUT_W     (OUT_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clkn_i       (clkn_i),
        .rstn_i       (rstn_i),
        .issue_i      (issue_i),
        .issue_ready_o(issue_ready_o),
        .product_i    (product_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_data_o   (res_data_o),
        .res_sat_o    (res_sat_o)
`ifdef RESULT_STICKY_SAT_EN
        ,
        .sat_clr_i    (sat_clr_i),
        .sat_sticky_o (sat_sticky_o)
`endif
    );

    always #5 clkn_i = ~clkn_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: round half-up at FRAC_BITS, clamp to OUT_W bits.
    function automatic res_t model_result(input logic [47:0] p);
        longint unsigned r;
        longint unsigned q;
        longint unsigned maxv;
        res_t            o;
        r    = 64'(p);
        if (FRAC_BITS > 0) r = r + (64'd1 << (FRAC_BITS - 1));
        q    = r >> FRAC_BITS;
        maxv = (64'd1 << OUT_W) - 64'd1;
        if (q > maxv) begin
            o.d = '1;
            o.s = 1'b1;
        end else begin
            o.d = q[OUT_W-1:0];
            o.s = 1'b0;
        end
        return o;
    endfunction

    function automatic logic [47:0] rand_product();
        logic [47:0] p;
        case ($urandom_range(0, 6))
            0:       p = 48'h000001_800000;
            1:       p = 48'hFFFFFF_FFFFFF;
            2:       p = 48'h000003_7FFFFF;
            3:       p = 48'hFFFFFF_800000;
            4:       p = 48'hFFFFFF_7FFFFF;
            default: p = {16'($urandom), 32'($urandom)};
        endcase
        return p;
    endfunction

    // Model: credits = FIFO_DEPTH - (ops in flight + results queued).
    initial begin : model
        bit   pop;
        bit   acc;
        res_t r;
        fifo_n = 0;
        cyc    = 0;
        forever begin
            @(posedge clkn_i);
            if (!rstn_i) begin
                inflight.delete();
                exp_q.delete();
                fifo_n = 0;
`ifdef RESULT_STICKY_SAT_EN
                m_sticky = 1'b0;
`endif
            end else begin
                pop = (fifo_n > 0) && res_ready_i;
                acc = issue_i && ((inflight.size() + fifo_n) < FIFO_DEPTH);
                if (inflight.size() > 0 && inflight[0] == cyc - MULT_LAT) begin
                    void'(inflight.pop_front());
                    r = model_result(product_i);
                    exp_q.push_back(r);
                    fifo_n++;
`ifdef RESULT_STICKY_SAT_EN
                    if (r.s) m_sticky = 1'b1;
                    else if (sat_clr_i) m_sticky = 1'b0;
                end else if (sat_clr_i) begin
                    m_sticky = 1'b0;
`endif
                end
                if (pop) fifo_n--;
                if (acc) inflight.push_back(cyc);
            end
            cyc++;
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clkn_i);
            if (!rstn_i) begin
                check("rst_valid", 64'(res_valid_o), 64'(0));
                check("rst_ready", 64'(issue_ready_o), 64'(1));
                check("rst_data", 64'(res_data_o), 64'(0));
                check("rst_sat", 64'(res_sat_o), 64'(0));
            end else begin
                check("issue_ready", 64'(issue_ready_o),
                      64'((inflight.size() + fifo_n) < FIFO_DEPTH));
                check("res_valid", 64'(res_valid_o), 64'(exp_q.size() != 0));
`ifdef RESULT_STICKY_SAT_EN
                check("sat_sticky", 64'(sat_sticky_o), 64'(m_sticky));
`endif
                if (res_valid_o && exp_q.size() != 0) begin
                    check("res_data", 64'(res_data_o), 64'(exp_q[0].d));
                    check("res_sat", 64'(res_sat_o), 64'(exp_q[0].s));
                    if (res_ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

`ifdef RESULT_STICKY_SAT_EN
    initial begin : sat_clr_drv
        forever begin
            @(posedge clkn_i);
            #1 sat_clr_i = ($urandom_range(0, 7) == 0);
        end
    end
`endif

    task automatic step();
        @(posedge clkn_i);
        #1;
    endtask

    initial begin : stimulus
        logic [47:0] dir_tab [5];
        int          n;
        bit          got;
        checks = 0;
        errors = 0;
        dir_tab[0] = 48'hFFFFFF_FFFFFF;
        dir_tab[1] = 48'h000003_7FFFFF;
        dir_tab[2] = 48'hFFFFFF_800000;
        dir_tab[3] = 48'hFFFFFF_7FFFFF;
        dir_tab[4] = 48'h000000_000000;

        repeat (3) step();
        rstn_i = 1'b1;

        // Single issue: result expected three cycles after the issue cycle.
        product_i   = 48'h000001_800000;
        res_ready_i = 1'b1;
        issue_i     = 1'b1;
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            issue_i = 1'b0;
            n++;
            got = res_valid_o;
        end
        check("issue_to_valid_latency", 64'(got ? n : 99), 64'(MULT_LAT + 1));
        repeat (3) step();

        for (int i = 0; i < 5; i++) begin
            product_i = dir_tab[i];
            issue_i   = 1'b1;
            step();
            issue_i = 1'b0;
            repeat (4) step();
        end

        // Stalled consumer with issue held: exactly FIFO_DEPTH accepted.
        res_ready_i = 1'b0;
        issue_i     = 1'b1;
        for (int i = 0; i < 8; i++) begin
            product_i = rand_product();
            step();
        end
        check("stalled_issue_ready", 64'(issue_ready_o), 64'(0));

        // Full FIFO: simultaneous pop and issue.
        res_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            product_i = rand_product();
            step();
        end
        issue_i = 1'b0;
        repeat (10) step();

        // Reset with two operations in flight.
        issue_i = 1'b1;
        product_i = 48'h000010_000000;
        repeat (2) step();
        issue_i = 1'b0;
        rstn_i  = 1'b0;
        step();
        rstn_i  = 1'b1;
        step();
        check("post_reset_ready", 64'(issue_ready_o), 64'(1));
        repeat (6) step();

        for (int i = 0; i < 400; i++) begin
            issue_i     = ($urandom_range(0, 1) == 1);
            res_ready_i = ($urandom_range(0, 3) != 0);
            product_i   = rand_product();
            step();
        end

        issue_i     = 1'b0;
        res_ready_i = 1'b1;
        repeat (20) step();
        check("drain_ready", 64'(issue_ready_o), 64'(1));
        check("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
